// File: rtl/ftdi_pkg.sv
// Shared definitions for the FTDI UART receive and transmit paths.
package ftdi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam logic FTDI_IDLE_LEVEL = 1'b1;

    // Clocks per oversample tick; integer division truncates.
    function automatic int unsigned baud_div(input int unsigned frequency,
                                             input int unsigned baud_rate,
                                             input int unsigned oversample);
        return frequency / (baud_rate * oversample);
    endfunction

endpackage

// File: rtl/ftdi_baud_tick.sv
// Free-running divider emitting a one-clock tick every DIV clocks.
module ftdi_baud_tick #(
    parameter int unsigned DIV = 27
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick_o
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q + CW'(1);
        tick_d = 1'b0;
        if (cnt_q == CW'(DIV - 1)) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/ftdi_uart_rx.sv
// Oversampling UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding a
// 2-entry FIFO with a valid/ready output and a full flag for host throttling.
module ftdi_uart_rx
    import ftdi_pkg::*;
#(
    parameter int unsigned FREQUENCY  = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       FTDI_TX,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       flow_stop,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int unsigned DIV   = baud_div(FREQUENCY, BAUD_RATE, OVERSAMPLE);
    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);

    logic tick;

    ftdi_baud_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick_o  (tick)
    );

    // Line synchroniser and edge history
    logic sync1_q, rxs_q, rxs_prev_q;

    // Framing FSM state
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] scnt_q, scnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             done_q, done_d;
    logic             frame_err_q, frame_err_d;

    // Push stage and FIFO
    logic             push_q;
    logic [7:0]       push_byte_q;
    logic [7:0]       mem_q [2];
    logic [7:0]       mem_d [2];
    logic             wr_q, wr_d, rd_q, rd_d;
    logic [1:0]       count_q, count_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             flow_stop_q, flow_stop_d;
    logic             overrun_q, overrun_d;
    logic             pop, wr_en;

`ifdef UART_RX_PARITY_EN
    logic par_bit_q, par_bit_d;
    logic par_bad_q, par_bad_d;
    logic push_par_q;
    logic parity_err_q, parity_err_d;
`endif

    wire full_sample = tick && (scnt_q == CNT_W'(OVERSAMPLE - 1));
    wire half_sample = tick && (scnt_q == CNT_W'(OVERSAMPLE / 2 - 1));

    always_comb begin
        state_d     = state_q;
        scnt_d      = scnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        done_d      = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d   = par_bit_q;
        par_bad_d   = par_bad_q;
`endif
        if (tick) scnt_d = scnt_q + CNT_W'(1);
        case (state_q)
            IDLE: begin
                scnt_d = scnt_q;
                if (rxs_prev_q && !rxs_q) begin
                    state_d = START;
                    scnt_d  = '0;
                end
            end
            START: if (half_sample) begin
                scnt_d  = '0;
                bit_d   = 3'd0;
                state_d = rxs_q ? IDLE : DATA;
            end
            DATA: if (full_sample) begin
                shift_d[bit_q] = rxs_q;
                scnt_d         = '0;
                bit_d          = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                if (bit_q == 3'd7) state_d = PARITY;
`else
                if (bit_q == 3'd7) state_d = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (full_sample) begin
                par_bit_d = rxs_q;
                scnt_d    = '0;
                state_d   = STOP;
            end
`endif
            STOP: if (full_sample) begin
                scnt_d = '0;
                if (rxs_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = (^shift_q) ^ par_bit_q;
`endif
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = BREAK;
                end
            end
            BREAK: begin
                scnt_d = '0;
                if (rxs_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO: a full push with a simultaneous pop reuses the slot being freed.
    always_comb begin
        pop       = valid_q && ready;
        wr_en     = push_q && ((count_q != 2'd2) || pop);
        overrun_d = push_q && (count_q == 2'd2) && !pop;
        mem_d     = mem_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        count_d   = count_q;
        if (wr_en) begin
            mem_d[wr_q] = push_byte_q;
            wr_d        = ~wr_q;
        end
        if (pop) rd_d = ~rd_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        valid_d     = (count_d != 2'd0);
        flow_stop_d = (count_d == 2'd2);
        data_d      = valid_d ? mem_d[rd_d] : data_q;
`ifdef UART_RX_PARITY_EN
        parity_err_d = push_q && push_par_q;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= FTDI_IDLE_LEVEL;
            rxs_q       <= FTDI_IDLE_LEVEL;
            rxs_prev_q  <= FTDI_IDLE_LEVEL;
            state_q     <= IDLE;
            scnt_q      <= '0;
            bit_q       <= 3'd0;
            shift_q     <= 8'd0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
            push_q      <= 1'b0;
            push_byte_q <= 8'd0;
            mem_q       <= '{default: 8'd0};
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            count_q     <= 2'd0;
            data_q      <= 8'd0;
            valid_q     <= 1'b0;
            flow_stop_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            par_bad_q    <= 1'b0;
            push_par_q   <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync1_q     <= FTDI_TX;
            rxs_q       <= sync1_q;
            rxs_prev_q  <= rxs_q;
            state_q     <= state_d;
            scnt_q      <= scnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            done_q      <= done_d;
            frame_err_q <= frame_err_d;
            push_q      <= done_q;
            if (done_q) push_byte_q <= shift_q;
            mem_q       <= mem_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            count_q     <= count_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            flow_stop_q <= flow_stop_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= par_bit_d;
            par_bad_q    <= par_bad_d;
            push_par_q   <= done_q && par_bad_q;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign flow_stop = flow_stop_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ftdi_uart_rx.sv
// Directed bench for ftdi_uart_rx at 50 MHz / 115200 baud / 16x (27 clk per tick).
module tb_ftdi_uart_rx;

    localparam int TICK_CLKS = 27;
    localparam int BIT_CLKS  = 16 * TICK_CLKS;

    logic       clk;
    logic       reset_n;
    logic       FTDI_TX;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       flow_stop;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int tests;
    int fails;

    logic [7:0] pops[$];
    int         fe_cnt;
    int         ov_cnt;
    int         pe_cnt;
    logic       fs_seen;

`ifdef UART_RX_PARITY_EN
    logic par_flip;
`endif

    ftdi_uart_rx #(
        .FREQUENCY  (50_000_000),
        .BAUD_RATE  (115_200),
        .OVERSAMPLE (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .FTDI_TX    (FTDI_TX),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .flow_stop  (flow_stop),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Observe pops and pulses mid-cycle; a pop takes effect at the following rising edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (valid && ready) pops.push_back(data);
            if (frame_err)  fe_cnt = fe_cnt + 1;
            if (overrun)    ov_cnt = ov_cnt + 1;
            if (parity_err) pe_cnt = pe_cnt + 1;
            if (flow_stop)  fs_seen = 1'b1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        pops.delete();
        fe_cnt  = 0;
        ov_cnt  = 0;
        pe_cnt  = 0;
        fs_seen = 1'b0;
    endtask

    task automatic line_bit(input logic b);
        FTDI_TX = b;
        step(BIT_CLKS);
    endtask

    // Leaves the line at stop_bit level after the frame.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        line_bit((^b) ^ par_flip);
`endif
        line_bit(stop_bit);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        FTDI_TX = 1'b1;
        ready   = 1'b0;
        step(5);
        tests++; if (data !== 8'h00)    begin fails++; $display("FAIL reset_data: got %h expected 00", data); end
        tests++; if (valid !== 1'b0)    begin fails++; $display("FAIL reset_valid: got %b expected 0", valid); end
        tests++; if (flow_stop !== 1'b0) begin fails++; $display("FAIL reset_flow_stop: got %b expected 0", flow_stop); end
        tests++; if ({frame_err, overrun, parity_err} !== 3'b000)
            begin fails++; $display("FAIL reset_pulses: got %b expected 000", {frame_err, overrun, parity_err}); end
        reset_n = 1'b1;
        step(BIT_CLKS);
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL post_reset_valid: got %b expected 0", valid); end
    endtask

    task automatic test_single_byte();
        ready = 1'b1;
        clear_mon();
        send_frame(8'h4A, 1'b1);
        step(16);
        tests++; if (pops.size() !== 1) begin fails++; $display("FAIL single_count: got %0d expected 1", pops.size()); end
        tests++; if (pops.size() > 0 && pops[0] !== 8'h4A)
            begin fails++; $display("FAIL single_data: got %h expected 4a", pops[0]); end
        tests++; if (fe_cnt + ov_cnt + pe_cnt !== 0)
            begin fails++; $display("FAIL single_pulses: got %0d expected 0", fe_cnt + ov_cnt + pe_cnt); end
        tests++; if (fs_seen !== 1'b0) begin fails++; $display("FAIL single_flow_stop: got %b expected 0", fs_seen); end
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL single_valid_after: got %b expected 0", valid); end
    endtask

    task automatic test_glitch();
        clear_mon();
        FTDI_TX = 1'b0;
        step(5 * TICK_CLKS);
        FTDI_TX = 1'b1;
        step(2 * BIT_CLKS);
        tests++; if (pops.size() !== 0) begin fails++; $display("FAIL glitch_pops: got %0d expected 0", pops.size()); end
        tests++; if (fe_cnt + ov_cnt + pe_cnt !== 0)
            begin fails++; $display("FAIL glitch_pulses: got %0d expected 0", fe_cnt + ov_cnt + pe_cnt); end
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL glitch_valid: got %b expected 0", valid); end
    endtask

    task automatic test_frame_error();
        ready = 1'b1;
        clear_mon();
        send_frame(8'h55, 1'b0);
        step(3 * BIT_CLKS);
        FTDI_TX = 1'b1;
        step(BIT_CLKS);
        tests++; if (fe_cnt !== 1) begin fails++; $display("FAIL break_frame_err: got %0d expected 1", fe_cnt); end
        tests++; if (pops.size() !== 0) begin fails++; $display("FAIL break_pops: got %0d expected 0", pops.size()); end
        tests++; if (pe_cnt !== 0) begin fails++; $display("FAIL break_parity_err: got %0d expected 0", pe_cnt); end
        send_frame(8'hA3, 1'b1);
        step(16);
        tests++; if (pops.size() !== 1) begin fails++; $display("FAIL recover_count: got %0d expected 1", pops.size()); end
        tests++; if (pops.size() > 0 && pops[0] !== 8'hA3)
            begin fails++; $display("FAIL recover_data: got %h expected a3", pops[0]); end
        tests++; if (fe_cnt !== 1) begin fails++; $display("FAIL recover_frame_err: got %0d expected 1", fe_cnt); end
    endtask

    task automatic test_back_to_back();
        ready = 1'b0;
        clear_mon();
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        step(4);
        tests++; if (flow_stop !== 1'b1) begin fails++; $display("FAIL b2b_full: got %b expected 1", flow_stop); end
        tests++; if (data !== 8'h01) begin fails++; $display("FAIL b2b_head: got %h expected 01", data); end
        send_frame(8'h03, 1'b1);
        step(4);
        tests++; if (ov_cnt !== 1) begin fails++; $display("FAIL b2b_overrun: got %0d expected 1", ov_cnt); end
        tests++; if (data !== 8'h01 || valid !== 1'b1)
            begin fails++; $display("FAIL b2b_hold: got %h/%b expected 01/1", data, valid); end
        ready = 1'b1;
        step(1);
        tests++; if (flow_stop !== 1'b0) begin fails++; $display("FAIL b2b_flow_release: got %b expected 0", flow_stop); end
        tests++; if (data !== 8'h02) begin fails++; $display("FAIL b2b_second_head: got %h expected 02", data); end
        step(3);
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL b2b_drained: got %b expected 0", valid); end
        tests++; if (pops.size() !== 2) begin fails++; $display("FAIL b2b_pop_count: got %0d expected 2", pops.size()); end
        tests++; if (pops.size() == 2 && (pops[0] !== 8'h01 || pops[1] !== 8'h02))
            begin fails++; $display("FAIL b2b_pop_order: got %h %h expected 01 02", pops[0], pops[1]); end
    endtask

    task automatic test_reset_midframe();
        ready = 1'b0;
        clear_mon();
        send_frame(8'h11, 1'b1);
        step(4);
        tests++; if (valid !== 1'b1) begin fails++; $display("FAIL midrst_preload: got %b expected 1", valid); end
        line_bit(1'b0);
        for (int i = 0; i < 4; i++) line_bit(1'b1);
        step(BIT_CLKS / 2);
        reset_n = 1'b0;
        step(3);
        tests++; if (valid !== 1'b0 || data !== 8'h00)
            begin fails++; $display("FAIL midrst_cleared: got %b/%h expected 0/00", valid, data); end
        tests++; if (flow_stop !== 1'b0) begin fails++; $display("FAIL midrst_flow_stop: got %b expected 0", flow_stop); end
        reset_n = 1'b1;
        step(2 * BIT_CLKS);
        ready = 1'b1;
        clear_mon();
        send_frame(8'h3C, 1'b1);
        step(16);
        tests++; if (pops.size() !== 1) begin fails++; $display("FAIL midrst_count: got %0d expected 1", pops.size()); end
        tests++; if (pops.size() > 0 && pops[0] !== 8'h3C)
            begin fails++; $display("FAIL midrst_data: got %h expected 3c", pops[0]); end
        tests++; if (fe_cnt + ov_cnt + pe_cnt !== 0)
            begin fails++; $display("FAIL midrst_pulses: got %0d expected 0", fe_cnt + ov_cnt + pe_cnt); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        ready = 1'b1;
        clear_mon();
        par_flip = 1'b1;
        send_frame(8'h4A, 1'b1);
        step(16);
        par_flip = 1'b0;
        tests++; if (pe_cnt !== 1) begin fails++; $display("FAIL parity_bad_pulse: got %0d expected 1", pe_cnt); end
        tests++; if (pops.size() !== 1 || pops[0] !== 8'h4A)
            begin fails++; $display("FAIL parity_bad_data: got %0d bytes head %h expected 1 byte 4a", pops.size(), pops[0]); end
        clear_mon();
        send_frame(8'h4A, 1'b1);
        step(16);
        tests++; if (pe_cnt !== 0) begin fails++; $display("FAIL parity_good_pulse: got %0d expected 0", pe_cnt); end
        tests++; if (pops.size() !== 1 || pops[0] !== 8'h4A)
            begin fails++; $display("FAIL parity_good_data: got %0d bytes head %h expected 1 byte 4a", pops.size(), pops[0]); end
    endtask
`endif

    initial begin
        tests   = 0;
        fails   = 0;
        reset_n = 1'b0;
        FTDI_TX = 1'b1;
        ready   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_flip = 1'b0;
`endif
        clear_mon();
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_reset_midframe();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
